// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
// Two-port request arbiter and sequencer in front of the four ALU sub-units
// (ARITH, LOGIC, CMP, SHIFT). It grants one requester and latches that
// requester's operands and op code. It enables the decoded unit for one
// cycle and waits UNIT_LATENCY edges for the unit's registered result. It
// then captures the result and returns it with a one-cycle done pulse.
//
// Optional build macro: ALU_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a tie (no round-robin pointer)
//   undefined -> round-robin between the two requesters (default)
//
// Parameters: IN_WIDTH (operand width), OUT_WIDTH (result width),
//             UNIT_LATENCY (1..4, enable-to-valid edges of the units)
// Ports:
//   clk, RST                     clock, synchronous active-high reset
//   req0/req1, A0/B0/FUN0, A1/B1/FUN1
//                                request levels, operands, op codes
//   gnt0/gnt1                    grant, high for the ISSUE cycle
//   A, B, ALU_FUN                shared operand/function bus to the units
//   *_Enable                     one-hot unit enables
//   *_OUT, *_Flag                registered unit results and flags
//   result, result_flag          captured result and flag
//   done0/done1                  completion pulse to the owner
//   busy                         high whenever the FSM is not idle
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no operation; arbitrate any pending request
// ISSUE | grant the owner and pulse the decoded unit enable
// WAIT  | count down the unit latency, then capture the result
// DONE  | pulse the owner's done; result valid
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int IN_WIDTH     = 8,
    parameter int OUT_WIDTH    = 16,
    parameter int UNIT_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [IN_WIDTH-1:0]  A0,
    input  logic [IN_WIDTH-1:0]  B0,
    input  logic [IN_WIDTH-1:0]  A1,
    input  logic [IN_WIDTH-1:0]  B1,
    input  logic [3:0]           FUN0,
    input  logic [3:0]           FUN1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [IN_WIDTH-1:0]  A,
    output logic [IN_WIDTH-1:0]  B,
    output logic [1:0]           ALU_FUN,
    output logic                 Arith_Enable,
    output logic                 Logic_Enable,
    output logic                 CMP_Enable,
    output logic                 Shift_Enable,
    input  logic [OUT_WIDTH-1:0] Arith_OUT,
    input  logic [OUT_WIDTH-1:0] Logic_OUT,
    input  logic [OUT_WIDTH-1:0] CMP_OUT,
    input  logic [OUT_WIDTH-1:0] Shift_OUT,
    input  logic                 Arith_Flag,
    input  logic                 Logic_Flag,
    input  logic                 CMP_Flag,
    input  logic                 Shift_Flag,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 result_flag,
    output logic                 done0,
    output logic                 done1,
    output logic                 busy
);

    localparam int CW = 2;  // holds UNIT_LATENCY-1 for latencies up to 4

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   owner_q;
    logic [IN_WIDTH-1:0]    a_q, b_q;
    logic [3:0]             fun_q;
    logic                   gnt0_q, gnt1_q;
    logic [3:0]             en_q;
    logic                   done0_q, done1_q;
    logic                   busy_q;
    logic [OUT_WIDTH-1:0]   result_q;
    logic                   flag_q;

    logic                   win_d;
    logic [3:0]             sel_fun_d;
    logic [OUT_WIDTH-1:0]   unit_res_d;
    logic                   unit_flag_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Only consulted when at least one request is high.
    assign win_d = ~req0;
`else
    logic ptr_q;  // 1: requester 1 wins the next tie
    assign win_d = (req0 && req1) ? ptr_q : req1;
`endif

    assign sel_fun_d = win_d ? FUN1 : FUN0;

    always_comb begin
        unit_res_d  = Arith_OUT;
        unit_flag_d = Arith_Flag;
        case (fun_q[3:2])
            2'b00: begin unit_res_d = Arith_OUT; unit_flag_d = Arith_Flag; end
            2'b01: begin unit_res_d = Logic_OUT; unit_flag_d = Logic_Flag; end
            2'b10: begin unit_res_d = CMP_OUT;   unit_flag_d = CMP_Flag;   end
            default: begin unit_res_d = Shift_OUT; unit_flag_d = Shift_Flag; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            en_q     <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= win_d;
                        a_q     <= win_d ? A1 : A0;
                        b_q     <= win_d ? B1 : B0;
                        fun_q   <= sel_fun_d;
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        en_q    <= 4'b0001 << sel_fun_d[3:2];
                        busy_q  <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        ptr_q   <= ~win_d;
`endif
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    en_q    <= '0;
                    cnt_q   <= CW'(UNIT_LATENCY - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        result_q <= unit_res_d;
                        flag_q   <= unit_flag_d;
                        done0_q  <= ~owner_q;
                        done1_q  <= owner_q;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    // Operand bus returns to 0 as the FSM goes idle.
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    a_q     <= '0;
                    b_q     <= '0;
                    fun_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q[1:0];
    assign Arith_Enable = en_q[0];
    assign Logic_Enable = en_q[1];
    assign CMP_Enable   = en_q[2];
    assign Shift_Enable = en_q[3];
    assign result       = result_q;
    assign result_flag  = flag_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

    logic        clk;
    logic        RST;
    logic        req0, req1, req0b, req1b;
    logic [7:0]  A0, B0, A1, B1;
    logic [3:0]  FUN0, FUN1;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

    logic        gnt0, gnt1, done0, done1, busy, result_flag;
    logic [7:0]  A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] result;

    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_result_flag;
    logic [7:0]  b_A, b_B;
    logic [1:0]  b_ALU_FUN;
    logic        b_Arith_Enable, b_Logic_Enable, b_CMP_Enable, b_Shift_Enable;
    logic [15:0] b_result;

    int nchecks = 0;
    int nerrors = 0;

    alu_req_arbiter #(.IN_WIDTH(8), .OUT_WIDTH(16), .UNIT_LATENCY(1)) dut (
        .clk(clk), .RST(RST), .req0(req0), .req1(req1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1), .FUN0(FUN0), .FUN1(FUN1),
        .gnt0(gnt0), .gnt1(gnt1), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .result(result), .result_flag(result_flag),
        .done0(done0), .done1(done1), .busy(busy)
    );

    alu_req_arbiter #(.IN_WIDTH(8), .OUT_WIDTH(16), .UNIT_LATENCY(3)) dut_l3 (
        .clk(clk), .RST(RST), .req0(req0b), .req1(req1b),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1), .FUN0(FUN0), .FUN1(FUN1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .A(b_A), .B(b_B), .ALU_FUN(b_ALU_FUN),
        .Arith_Enable(b_Arith_Enable), .Logic_Enable(b_Logic_Enable),
        .CMP_Enable(b_CMP_Enable), .Shift_Enable(b_Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .result(b_result), .result_flag(b_result_flag),
        .done0(b_done0), .done1(b_done1), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output int polls);
        polls = 0;
        do begin
            tick();
            polls++;
        end while (!(gnt0 || gnt1) && polls < 10);
        chk("gnt_seen", {31'd0, gnt0 | gnt1}, 32'd1);
    endtask

    initial begin
        int polls;
        int exp_owner;

        // Distinct unit outputs so a wrong decode is visible.
        Arith_OUT = 16'd48;    Arith_Flag = 1'b0;
        Logic_OUT = 16'h00AA;  Logic_Flag = 1'b0;
        CMP_OUT   = 16'd2;     CMP_Flag   = 1'b1;
        Shift_OUT = 16'h0100;  Shift_Flag = 1'b1;
        A0 = 8'd50; B0 = 8'd15; FUN0 = 4'b1010;
        A1 = 8'd7;  B1 = 8'd3;  FUN1 = 4'b1111;
        req0 = 1'b1; req1 = 1'b0; req0b = 1'b0; req1b = 1'b0;
        RST = 1'b1;

        // Reset held two cycles with req0 high.
        tick(); tick();
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_A", {24'd0, A}, 32'd0);
        chk("rst_fun", {30'd0, ALU_FUN}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_en", {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 32'd0);
        RST = 1'b0;

        // Single CMP op; req dropped right after the grant.
        tick();
        chk("cmp_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        chk("cmp_en", {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 32'b0100);
        chk("cmp_fun", {30'd0, ALU_FUN}, 32'd2);
        chk("cmp_A", {24'd0, A}, 32'd50);
        chk("cmp_B", {24'd0, B}, 32'd15);
        chk("cmp_busy", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        tick();
        chk("cmp_wait_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("cmp_wait_en", {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 32'd0);
        chk("cmp_wait_A", {24'd0, A}, 32'd50);
        chk("cmp_wait_done", {30'd0, done1, done0}, 32'd0);
        tick();
        chk("cmp_done", {30'd0, done1, done0}, 32'd1);
        chk("cmp_result", {16'd0, result}, 32'd2);
        chk("cmp_flag", {31'd0, result_flag}, 32'd1);
        tick();
        chk("cmp_after_done", {30'd0, done1, done0}, 32'd0);
        chk("cmp_idle_busy", {31'd0, busy}, 32'd0);
        chk("cmp_idle_A", {24'd0, A}, 32'd0);
        chk("cmp_hold_result", {16'd0, result}, 32'd2);

        // Tie from a fresh reset: pointer starts favouring requester 0.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        FUN0 = 4'b0100;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_owner = 0;
`else
            exp_owner = i % 2;
`endif
            wait_gnt(polls);
            if (i > 0) chk("tie_gap", polls, 32'd2);
            chk("tie_gnt", {30'd0, gnt1, gnt0}, (exp_owner == 1) ? 32'b10 : 32'b01);
            chk("tie_fun", {30'd0, ALU_FUN}, (exp_owner == 1) ? 32'd3 : 32'd0);
            chk("tie_en", {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable},
                (exp_owner == 1) ? 32'b1000 : 32'b0010);
            tick(); tick();
            chk("tie_done", {30'd0, done1, done0}, (exp_owner == 1) ? 32'b10 : 32'b01);
            chk("tie_result", {16'd0, result}, (exp_owner == 1) ? 32'h0100 : 32'h00AA);
            chk("tie_flag", {31'd0, result_flag}, (exp_owner == 1) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Late request: req1 rises during WAIT of a req0 op.
        req0 = 1'b1;
        tick();
        chk("late_gnt0", {30'd0, gnt1, gnt0}, 32'b01);
        req0 = 1'b0;
        tick();
        req1 = 1'b1;
        tick();
        chk("late_done0", {30'd0, done1, done0}, 32'b01);
        chk("late_hold_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        tick();
        chk("late_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("late_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("late_gnt1", {30'd0, gnt1, gnt0}, 32'b10);
        chk("late_A1", {24'd0, A}, 32'd7);
        req1 = 1'b0;
        tick(); tick();
        chk("late_done1", {30'd0, done1, done0}, 32'b10);
        chk("late_result", {16'd0, result}, 32'h0100);
        tick();

        // UNIT_LATENCY=3 instance, ARITH 25+23.
        A0 = 8'd25; B0 = 8'd23; FUN0 = 4'b0000;
        req0b = 1'b1;
        tick();
        chk("l3_gnt0", {30'd0, b_gnt1, b_gnt0}, 32'b01);
        chk("l3_en", {28'd0, b_Shift_Enable, b_CMP_Enable, b_Logic_Enable, b_Arith_Enable}, 32'b0001);
        chk("l3_A", {24'd0, b_A}, 32'd25);
        req0b = 1'b0;
        tick();
        chk("l3_en_off", {28'd0, b_Shift_Enable, b_CMP_Enable, b_Logic_Enable, b_Arith_Enable}, 32'd0);
        chk("l3_nodone1", {31'd0, b_done0}, 32'd0);
        tick();
        chk("l3_nodone2", {31'd0, b_done0}, 32'd0);
        tick();
        chk("l3_nodone3", {31'd0, b_done0}, 32'd0);
        tick();
        chk("l3_done", {30'd0, b_done1, b_done0}, 32'b01);
        chk("l3_result", {16'd0, b_result}, 32'd48);
        chk("l3_flag", {31'd0, b_result_flag}, 32'd0);
        tick();
        chk("l3_done_off", {31'd0, b_done0}, 32'd0);
        chk("l3_idle_busy", {31'd0, b_busy}, 32'd0);

        // Reset during WAIT drops the operation.
        FUN0 = 4'b1010;
        req0 = 1'b1;
        tick();
        chk("mid_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        chk("mid_done", {30'd0, done1, done0}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_result", {16'd0, result}, 32'd0);
        chk("mid_A", {24'd0, A}, 32'd0);
        RST = 1'b0;
        tick();
        chk("mid_after_done", {30'd0, done1, done0}, 32'd0);
        chk("mid_after_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-port request arbiter and sequencer for the hierarchical ALU. Two requesters each present a 4-bit operation code and two operands. The block grants one requester, drives the selected unit (ARITH, LOGIC, CMP, SHIFT) with its enable and 2-bit `ALU_FUN`, and waits the unit's registered latency. It then captures that unit's result and flag and returns them to the granted requester with a one-cycle done pulse. It sits between the command sources and the four ALU sub-units, which it shares one operation at a time.

## Interface

- `IN_WIDTH`, 8, operand width
- `OUT_WIDTH`, 16, result width
- `UNIT_LATENCY`, 1, clock edges from unit enable to valid registered unit output; legal range 1..4

- `clk`  in  1  clock; all logic on rising edge
- `RST`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  request level per requester
- `A0`, `B0`, `A1`, `B1`  in  IN_WIDTH  operands per requester
- `FUN0`, `FUN1`  in  4  operation code:
  - [3:2] selects the unit: 00 ARITH, 01 LOGIC, 10 CMP, 11 SHIFT
  - [1:0] is the unit's `ALU_FUN`
- `gnt0`, `gnt1`  out  1  grant, high for the ISSUE cycle only
- `A`, `B`  out  IN_WIDTH  shared operand bus to units
- `ALU_FUN`  out  2  shared function select to units
- `Arith_Enable`, `Logic_Enable`, `CMP_Enable`, `Shift_Enable`  out  1  unit enables; at most one high
- `Arith_OUT`, `Logic_OUT`, `CMP_OUT`, `Shift_OUT`  in  OUT_WIDTH  registered unit results
- `Arith_Flag`, `Logic_Flag`, `CMP_Flag`, `Shift_Flag`  in  1  unit valid flags
- `result`  out  OUT_WIDTH  captured result
- `result_flag`  out  1  captured flag
- `done0`, `done1`  out  1  completion pulse to the granted requester
- `busy`  out  1  high in every state except IDLE

## Operation

- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If neither req is high, stay in IDLE.
  - Otherwise pick a winner, latch its A/B/FUN and the owner id, and go to ISSUE.
- **Arbitration:**
  - Single request: that requester wins.
  - Both requesting: the requester not granted last wins (round-robin pointer, updated on every grant).
  - After reset the pointer favours requester 0.
- **ISSUE (1 cycle):**
  - Assert the owner's gnt.
  - Drive A/B/ALU_FUN from the latched values.
  - Assert the enable decoded from FUN[3:2].
  - Load the wait counter with UNIT_LATENCY-1 and go to WAIT.
- **WAIT:**
  - A/B/ALU_FUN stay on the latched values; all enables are low.
  - Decrement the counter each cycle.
  - When the counter reads 0, capture the decoded unit's OUT and Flag into result/result_flag, then go to DONE.
- **DONE (1 cycle):**
  - Owner's done high; result/result_flag valid.
  - Go to IDLE.
- **Requester rules:**
  - req is level; the operand inputs are sampled only on the IDLE grant edge.
  - Dropping req after the grant does not abort the operation; done still pulses.
  - A req still high in the cycle after done is a new request.
- result/result_flag hold their value until the next capture.
- A/B/ALU_FUN outputs are 0 in IDLE.
- No FUN code is illegal; all 16 codes decode.

## Timing

- **Reset:** RST sampled high at an edge forces the following:
  - state IDLE, pointer set to favour requester 0, counter 0;
  - all gnt/done/enables/busy 0;
  - A, B, ALU_FUN, result, result_flag all 0.
- **Reset mid-operation:** the in-flight operation is dropped; no done is produced.
- **Latency:** req sampled at edge N:
  - gnt and enable high in cycle N..N+1;
  - capture at edge N+1+UNIT_LATENCY;
  - done high in cycle N+1+UNIT_LATENCY..N+2+UNIT_LATENCY.
  - With UNIT_LATENCY=1, done is high during the third cycle after the request edge.
- **Throughput:** one operation per UNIT_LATENCY+3 cycles. Re-arbitration happens only from IDLE.
- **Simultaneous events:**
  - A request arriving during a busy state is held off, with no gnt, until IDLE.
  - Both reqs high in IDLE resolve per the pointer in the same edge.

## Configuration

- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; requester 0 always wins a tie.
  - The pointer logic is removed.
- Undefined (default): round-robin as described above.

## Test plan

- **Reset:** hold RST high for 2 cycles with req0=1 -> all outputs 0, no gnt. Release -> gnt0 on the next cycle.
- **Single CMP op:** req0, A0=50, B0=15, FUN0=4'b1010, unit model returns CMP_OUT=2 and flag=1 -> CMP_Enable and ALU_FUN=2'b10 for one cycle; done0 with result=16'd2, result_flag=1 at N+3 (UNIT_LATENCY=1).
- **Tie, round-robin:** req0=req1=1 continuously -> grant sequence 0,1,0,1; each done matches its owner. With `ALU_ARB_FIXED_PRIO_EN` -> 0,0,0.
- **Late request:** req1 rises during WAIT of a req0 op -> gnt1 only after done0, in the cycle following return to IDLE.
- **Latency:** UNIT_LATENCY=3, ARITH op A=25, B=23, FUN=4'b0000, ARITH_OUT=48 -> enable high 1 cycle; done at N+5 with result=48.
- **Reset mid-op:** RST pulsed during WAIT -> no done; busy=0 and result=0 the next cycle.
